qdec_nal_unpacker: RTL and testbench
====================================

QDEC_NAL_UNPACKER -- requirements
Module: qdec_nal_unpacker

Interface
REQ-001 Parameter: CNT_W, default 16, width of the emulation-prevention-byte counter.
REQ-002 clk  input  1  single clock for the block.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_byte  input  8  raw Annex-B byte stream from the external RAM reader.
REQ-005 in_vld  input  1  in_byte valid.
REQ-006 in_rdy  output  1  block accepts in_byte this cycle.
REQ-007 out_byte  output  8  RBSP payload byte; drives the CABAC bitstreamFetch input.
REQ-008 out_vld  output  1  out_byte valid; drives bitstreamFetch_vld.
REQ-009 out_rdy  input  1  downstream accepts; driven by bitstreamFetch_rdy.
REQ-010 nal_type  output  6  nal_unit_type of the current NAL unit.
REQ-011 nal_tid  output  3  nuh_temporal_id_plus1 minus 1.
REQ-012 nal_hdr_vld  output  1  one-cycle pulse when nal_type and nal_tid update.
REQ-013 epb_cnt  output  CNT_W  count of removed 0x03 bytes since reset, wraps at 2^CNT_W.
REQ-014 error_intr  output  1  one-cycle pulse on a stream syntax error.

Function
REQ-015 The FSM SHALL have states SEARCH, HDR0, HDR1, PAYLOAD, and FLUSH.
REQ-016 The block SHALL track zcnt, a 2-bit count of consecutive input 0x00 bytes that saturates at 3; zeros are counted and held, not emitted immediately.
REQ-017 A byte is accepted when in_vld && in_rdy.
REQ-018 in_rdy SHALL be 0 in FLUSH, and 0 whenever out_vld=1 && out_rdy=0.
REQ-019 SEARCH: on 0x01 with zcnt>=2, go to HDR0 and clear zcnt; all other bytes are discarded and update zcnt only.
REQ-020 HDR0: the byte is latched as header byte 0; bit7 (forbidden_zero_bit)=1 pulses error_intr; go to HDR1.
REQ-021 HDR1: nal_type is set to hdr0[6:1], nal_tid to byte[2:0]-1, nal_hdr_vld pulses in the next cycle, go to PAYLOAD.
REQ-022 HDR1: a byte with [2:0]=0 pulses error_intr, and nal_tid is set to 0.
REQ-023 PAYLOAD, byte 0x00: zcnt is incremented; nothing is emitted.
REQ-024 PAYLOAD, zcnt>=2 and byte 0x01: start code; held zeros are discarded, zcnt is cleared, go to HDR0.
REQ-025 PAYLOAD, zcnt=2 and byte 0x03: emulation prevention; emit 00 00, drop the 0x03, increment epb_cnt, clear zcnt.
REQ-026 PAYLOAD, zcnt=2 and byte 0x02: error_intr pulses, the byte and held zeros are dropped, zcnt is cleared.
REQ-027 PAYLOAD, zcnt=3 and byte not 0x00/0x01: error_intr pulses, the byte and held zeros are dropped, zcnt is cleared.
REQ-028 PAYLOAD, any other nonzero byte: emit zcnt zeros followed by the byte, then clear zcnt.
REQ-029 Held zeros SHALL be emitted in FLUSH, one per out handshake, with the trigger byte kept in a hold register and emitted last; on completion return to PAYLOAD.
REQ-030 Latency: an accepted payload byte with zcnt=0 SHALL appear on out_byte with out_vld=1 the next cycle.
REQ-031 Throughput SHALL be 1 byte/cycle when out_rdy=1 and no zeros are held.
REQ-032 Output handshake: while out_vld=1 && out_rdy=0, out_byte SHALL hold stable and out_vld SHALL stay 1; no byte is duplicated or lost.
REQ-033 If error_intr and nal_hdr_vld events fall in the same cycle, both pulses SHALL be issued; error_intr SHALL NOT change the state except as stated above.

Reset
REQ-034 While rst_n=0, and in the cycle after its release, the state SHALL be SEARCH, with zcnt=0, hold register empty, in_rdy=0 during reset, out_vld=0, out_byte=0, nal_type=0, nal_tid=0, nal_hdr_vld=0, epb_cnt=0, error_intr=0.
REQ-035 Reset asserted mid-FLUSH or mid-stall SHALL discard all held and pending bytes immediately.
REQ-036 in_rdy SHALL be 1 in the first cycle after reset release.

Verification
REQ-037 Input 00 00 01 40 01 AA BB -> nal_hdr_vld pulse with nal_type=32, nal_tid=0; out_byte sequence AA, BB.
REQ-038 Payload AA 00 00 03 01 BB -> out AA 00 00 01 BB; epb_cnt=1; no nal_hdr_vld.
REQ-039 Payload AA BB CC with out_rdy=0 for 5 cycles after AA is presented -> AA stays on out_byte, in_rdy=0, then AA BB CC are emitted exactly once.
REQ-040 Payload AA 00 00 02 BB -> one error_intr pulse; out AA BB only.
REQ-041 Payload AA 00 00 00 01 42 01 CC -> out AA only, then nal_hdr_vld with nal_type=33, then out CC.
REQ-042 rst_n pulsed low during FLUSH of payload 00 55 -> all outputs 0 and state SEARCH; subsequent 00 00 01 40 01 decodes normally.

Source files
------------

// File: rtl/qdec_nal_unpacker_if.sv
// Byte-stream bus between the Annex-B reader, the NAL unpacker and the CABAC bitstream fetch.
// The slave modport is the unpacker's view; the master modport is its environment's view.
interface qdec_nal_unpacker_if #(
  parameter int unsigned CNT_W = 16
) ();

  logic [7:0]       in_byte;
  logic             in_vld;
  logic             in_rdy;
  logic [7:0]       out_byte;
  logic             out_vld;
  logic             out_rdy;
  logic [5:0]       nal_type;
  logic [2:0]       nal_tid;
  logic             nal_hdr_vld;
  logic [CNT_W-1:0] epb_cnt;
  logic             error_intr;

  modport slave (
    input  in_byte,
    input  in_vld,
    output in_rdy,
    output out_byte,
    output out_vld,
    input  out_rdy,
    output nal_type,
    output nal_tid,
    output nal_hdr_vld,
    output epb_cnt,
    output error_intr
  );

  modport master (
    output in_byte,
    output in_vld,
    input  in_rdy,
    input  out_byte,
    input  out_vld,
    output out_rdy,
    input  nal_type,
    input  nal_tid,
    input  nal_hdr_vld,
    input  epb_cnt,
    input  error_intr
  );

endinterface

// File: rtl/qdec_nal_unpacker.sv
// Annex-B NAL unpacker: locates start codes, decodes the two-byte NAL header and strips
// emulation-prevention bytes, presenting the RBSP as a valid/ready byte stream.
module qdec_nal_unpacker #(
  parameter int unsigned CNT_W = 16
) (
  input logic                clk,
  input logic                rst_n,
  qdec_nal_unpacker_if.slave bus
);

  typedef enum logic [2:0] {
    StSearch,
    StHdr0,
    StHdr1,
    StPayload,
    StFlush
  } state_e;

  state_e           r_state;
  logic [1:0]       r_zcnt;
  logic [1:0]       r_rem;
  logic [7:0]       r_hold;
  logic             r_hold_vld;
  logic [7:0]       r_hdr0;
  logic [7:0]       r_out_byte;
  logic             r_out_vld;
  logic [5:0]       r_nal_type;
  logic [2:0]       r_nal_tid;
  logic             r_hdr_vld;
  logic [CNT_W-1:0] r_epb_cnt;
  logic             r_err;

  logic       w_out_free;
  logic       w_in_rdy;
  logic       w_acc;
  logic [7:0] w_byte;
  logic [1:0] w_zinc;
  logic [2:0] w_tid;

  // The output register can take a new byte when empty or being drained this cycle.
  assign w_out_free = ~r_out_vld | bus.out_rdy;
  assign w_in_rdy   = rst_n & (r_state != StFlush) & w_out_free;
  assign w_acc      = bus.in_vld & w_in_rdy;
  assign w_byte     = bus.in_byte;
  assign w_zinc     = (r_zcnt == 2'd3) ? 2'd3 : r_zcnt + 2'd1;
  assign w_tid      = w_byte[2:0] - 3'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StSearch;
      r_zcnt     <= 2'd0;
      r_rem      <= 2'd0;
      r_hold     <= 8'h00;
      r_hold_vld <= 1'b0;
      r_hdr0     <= 8'h00;
      r_out_byte <= 8'h00;
      r_out_vld  <= 1'b0;
      r_nal_type <= 6'd0;
      r_nal_tid  <= 3'd0;
      r_hdr_vld  <= 1'b0;
      r_epb_cnt  <= '0;
      r_err      <= 1'b0;
    end else begin
      r_hdr_vld <= 1'b0;
      r_err     <= 1'b0;
      if (w_out_free) begin
        r_out_vld <= 1'b0;
      end

      case (r_state)
        StSearch: begin
          if (w_acc) begin
            if (w_byte == 8'h00) begin
              r_zcnt <= w_zinc;
            end else if (w_byte == 8'h01 && r_zcnt >= 2'd2) begin
              r_zcnt  <= 2'd0;
              r_state <= StHdr0;
            end else begin
              r_zcnt <= 2'd0;
            end
          end
        end

        StHdr0: begin
          if (w_acc) begin
            r_hdr0  <= w_byte;
            r_err   <= w_byte[7];
            r_state <= StHdr1;
          end
        end

        StHdr1: begin
          if (w_acc) begin
            r_nal_type <= r_hdr0[6:1];
            r_hdr_vld  <= 1'b1;
            if (w_byte[2:0] == 3'd0) begin
              r_err     <= 1'b1;
              r_nal_tid <= 3'd0;
            end else begin
              r_nal_tid <= w_tid;
            end
            r_state <= StPayload;
          end
        end

        StPayload: begin
          if (w_acc) begin
            if (w_byte == 8'h00) begin
              r_zcnt <= w_zinc;
            end else if (w_byte == 8'h01 && r_zcnt >= 2'd2) begin
              r_zcnt  <= 2'd0;
              r_state <= StHdr0;
            end else if (w_byte == 8'h03 && r_zcnt == 2'd2) begin
              // Emulation prevention: both zeros go out, the 0x03 is dropped.
              r_out_byte <= 8'h00;
              r_out_vld  <= 1'b1;
              r_rem      <= 2'd1;
              r_hold_vld <= 1'b0;
              r_epb_cnt  <= r_epb_cnt + CNT_W'(1);
              r_zcnt     <= 2'd0;
              r_state    <= StFlush;
            end else if ((w_byte == 8'h02 && r_zcnt == 2'd2) || r_zcnt == 2'd3) begin
              r_err  <= 1'b1;
              r_zcnt <= 2'd0;
            end else if (r_zcnt == 2'd0) begin
              r_out_byte <= w_byte;
              r_out_vld  <= 1'b1;
            end else begin
              // First held zero goes out now; the rest and the trigger byte follow in flush.
              r_out_byte <= 8'h00;
              r_out_vld  <= 1'b1;
              r_hold     <= w_byte;
              r_hold_vld <= 1'b1;
              r_rem      <= r_zcnt - 2'd1;
              r_zcnt     <= 2'd0;
              r_state    <= StFlush;
            end
          end
        end

        StFlush: begin
          if (w_out_free) begin
            r_out_vld <= 1'b1;
            if (r_rem != 2'd0) begin
              r_out_byte <= 8'h00;
              r_rem      <= r_rem - 2'd1;
              if (r_rem == 2'd1 && !r_hold_vld) begin
                r_state <= StPayload;
              end
            end else begin
              r_out_byte <= r_hold;
              r_hold_vld <= 1'b0;
              r_state    <= StPayload;
            end
          end
        end

        default: r_state <= StSearch;
      endcase
    end
  end

  assign bus.in_rdy      = w_in_rdy;
  assign bus.out_byte    = r_out_byte;
  assign bus.out_vld     = r_out_vld;
  assign bus.nal_type    = r_nal_type;
  assign bus.nal_tid     = r_nal_tid;
  assign bus.nal_hdr_vld = r_hdr_vld;
  assign bus.epb_cnt     = r_epb_cnt;
  assign bus.error_intr  = r_err;

endmodule

// File: tb/tb_qdec_nal_unpacker.sv
// Self-checking bench for qdec_nal_unpacker: directed vector table, hand-written handshake and
// reset sequences, and randomized streams scored against a stream-level reference model.
module tb_qdec_nal_unpacker;

  logic clk = 1'b0;
  logic rst_n;
  logic man_rdy;
  logic rand_rdy;
  logic rnd_rdy;

  qdec_nal_unpacker_if #(.CNT_W(16)) bus ();

  qdec_nal_unpacker #(.CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  assign bus.out_rdy = rand_rdy ? rnd_rdy : man_rdy;

  initial rnd_rdy = 1'b1;
  always @(posedge clk) begin
    #1;
    rnd_rdy = ($urandom_range(0, 3) != 0);
  end

  int n_pass  = 0;
  int n_total = 0;

  // Monitor: the only writer of the captured queues and counters.
  logic [7:0] got_out[$];
  logic [8:0] got_hdr[$];
  int         got_err   = 0;
  int         stall_bad = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_byte  = 8'h00;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!bus.out_vld || bus.out_byte != prev_byte)) stall_bad++;
      if (bus.out_vld && !bus.out_rdy && bus.in_rdy) stall_bad++;
      if (bus.out_vld && bus.out_rdy) got_out.push_back(bus.out_byte);
      if (bus.nal_hdr_vld) got_hdr.push_back({bus.nal_type, bus.nal_tid});
      if (bus.error_intr) got_err++;
      prev_stall = bus.out_vld && !bus.out_rdy;
      prev_byte  = bus.out_byte;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic acc;
    acc = 1'b0;
    bus.in_byte = b;
    bus.in_vld  = 1'b1;
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      if (bus.in_rdy) begin
        acc = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_vld = 1'b0;
    if (!acc) check("in_accept_timeout", {63'd0, acc}, 64'd1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n      = 1'b0;
    bus.in_vld = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic send_hdr(input logic [7:0] h0, input logic [7:0] h1);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(h0);
    send_byte(h1);
  endtask

  // Stream-level reference model over the whole input stream.
  logic [7:0] stim[$];
  logic [7:0] exp_out[$];
  logic [8:0] exp_hdr[$];
  int         exp_err;
  int         exp_epb;

  task automatic model_run();
    int         mode;
    int         z;
    logic [7:0] b;
    logic [7:0] h0;
    logic [2:0] tid;
    mode = 0;
    z    = 0;
    h0   = 8'h00;
    exp_out.delete();
    exp_hdr.delete();
    exp_err = 0;
    exp_epb = 0;
    foreach (stim[i]) begin
      b = stim[i];
      if (mode == 1) begin
        h0 = b;
        if (b[7]) exp_err++;
        mode = 2;
      end else if (mode == 2) begin
        if (b[2:0] == 3'd0) begin
          tid = 3'd0;
          exp_err++;
        end else begin
          tid = b[2:0] - 3'd1;
        end
        exp_hdr.push_back({h0[6:1], tid});
        mode = 3;
      end else if (b == 8'h00) begin
        z++;
      end else if (b == 8'h01 && z >= 2) begin
        mode = 1;
        z    = 0;
      end else if (mode == 0) begin
        z = 0;
      end else if (b == 8'h03 && z == 2) begin
        exp_out.push_back(8'h00);
        exp_out.push_back(8'h00);
        exp_epb++;
        z = 0;
      end else if ((b == 8'h02 && z == 2) || z >= 3) begin
        exp_err++;
        z = 0;
      end else begin
        repeat (z) exp_out.push_back(8'h00);
        exp_out.push_back(b);
        z = 0;
      end
    end
  endtask

  function automatic logic [7:0] rnd_byte();
    int r;
    r = $urandom_range(0, 9);
    if (r <= 3) return 8'h00;
    if (r == 4) return 8'h03;
    if (r == 5) return 8'h01;
    if (r == 6) return 8'h02;
    return 8'($urandom_range(0, 255));
  endfunction

  typedef struct {
    string        name;
    int           n_in;
    logic [127:0] in_b;
    int           n_out;
    logic [63:0]  out_b;
    int           hdrs;
    logic [5:0]   typ;
    logic [2:0]   tid;
    int           errs;
    int           epb;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs[NV];

  initial begin
    int         ob;
    int         hb;
    int         eb;
    int         bad;
    logic [63:0] v;
    logic [8:0]  lastv;
    logic [7:0]  prev;

    vecs[0]  = '{"basic", 7, 128'h00_00_01_40_01_AA_BB, 2, 64'hAA_BB, 1, 6'd32, 3'd0, 0, 0};
    vecs[1]  = '{"epb", 11, 128'h00_00_01_40_01_AA_00_00_03_01_BB,
                 5, 64'hAA_00_00_01_BB, 1, 6'd32, 3'd0, 0, 1};
    vecs[2]  = '{"err_0002", 10, 128'h00_00_01_40_01_AA_00_00_02_BB,
                 2, 64'hAA_BB, 1, 6'd32, 3'd0, 1, 0};
    vecs[3]  = '{"new_nal", 13, 128'h00_00_01_40_01_AA_00_00_00_01_42_01_CC,
                 2, 64'hAA_CC, 2, 6'd33, 3'd0, 0, 0};
    vecs[4]  = '{"z1_03", 8, 128'h00_00_01_40_01_00_03_11, 3, 64'h00_03_11, 1, 6'd32, 3'd0, 0, 0};
    vecs[5]  = '{"z2_04", 8, 128'h00_00_01_40_01_00_00_04, 3, 64'h00_00_04, 1, 6'd32, 3'd0, 0, 0};
    vecs[6]  = '{"z3_err", 10, 128'h00_00_01_40_01_00_00_00_05_66,
                 1, 64'h66, 1, 6'd32, 3'd0, 1, 0};
    vecs[7]  = '{"tid0_err", 6, 128'h00_00_01_40_00_AA, 1, 64'hAA, 1, 6'd32, 3'd0, 1, 0};
    vecs[8]  = '{"fzb_err", 6, 128'h00_00_01_C2_03_77, 1, 64'h77, 1, 6'd33, 3'd2, 1, 0};
    vecs[9]  = '{"search", 9, 128'h12_00_00_00_01_40_02_00_AA,
                 2, 64'h00_AA, 1, 6'd32, 3'd1, 0, 0};
    vecs[10] = '{"epb_x2", 11, 128'h00_00_01_40_01_00_00_03_00_00_03,
                 4, 64'h00_00_00_00, 1, 6'd32, 3'd0, 0, 2};

    rst_n       = 1'b0;
    bus.in_byte = 8'h00;
    bus.in_vld  = 1'b0;
    man_rdy     = 1'b1;
    rand_rdy    = 1'b0;

    // Reset values, during and just after reset.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 64'({bus.in_rdy, bus.out_vld, bus.out_byte, bus.nal_type, bus.nal_tid,
                                bus.nal_hdr_vld, bus.error_intr, bus.epb_cnt}), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset", 64'({bus.in_rdy, bus.out_vld, bus.out_byte, bus.nal_type, bus.nal_tid,
                             bus.nal_hdr_vld, bus.error_intr, bus.epb_cnt}), 64'({1'b1, 36'd0}));

    // Directed vector table.
    for (int k = 0; k < NV; k++) begin
      do_reset();
      ob = got_out.size();
      hb = got_hdr.size();
      eb = got_err;
      for (int i = 0; i < vecs[k].n_in; i++) send_byte(vecs[k].in_b[8*(vecs[k].n_in-1-i) +: 8]);
      repeat (8) @(posedge clk);
      #1;
      v = 64'd0;
      for (int i = ob; i < got_out.size(); i++) v = {v[55:0], got_out[i]};
      lastv = (got_hdr.size() > hb) ? got_hdr[got_hdr.size()-1] : 9'h1FF;
      check({vecs[k].name, ".out_len"}, 64'(got_out.size() - ob), 64'(vecs[k].n_out));
      check({vecs[k].name, ".out_bytes"}, v, vecs[k].out_b);
      check({vecs[k].name, ".hdr_cnt"}, 64'(got_hdr.size() - hb), 64'(vecs[k].hdrs));
      check({vecs[k].name, ".hdr_last"}, 64'(lastv), 64'({vecs[k].typ, vecs[k].tid}));
      check({vecs[k].name, ".err_cnt"}, 64'(got_err - eb), 64'(vecs[k].errs));
      check({vecs[k].name, ".epb_cnt"}, 64'(bus.epb_cnt), 64'(vecs[k].epb));
    end

    // Downstream stall: AA held, input blocked, then AA BB CC exactly once.
    do_reset();
    send_hdr(8'h40, 8'h01);
    ob = got_out.size();
    man_rdy = 1'b0;
    send_byte(8'hAA);
    bus.in_byte = 8'hBB;
    bus.in_vld  = 1'b1;
    bad = 0;
    eb  = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!bus.out_vld || bus.out_byte != 8'hAA) bad++;
      if (bus.in_rdy) eb++;
    end
    check("stall.out_held", 64'(bad), 64'd0);
    check("stall.in_rdy_low", 64'(eb), 64'd0);
    bus.in_vld = 1'b0;
    man_rdy    = 1'b1;
    @(posedge clk);
    #1;
    send_byte(8'hBB);
    send_byte(8'hCC);
    repeat (6) @(posedge clk);
    #1;
    v = 64'd0;
    for (int i = ob; i < got_out.size(); i++) v = {v[55:0], got_out[i]};
    check("stall.out_len", 64'(got_out.size() - ob), 64'd3);
    check("stall.out_bytes", v, 64'hAA_BB_CC);

    // Back-to-back payload: one-cycle latency and full throughput.
    do_reset();
    send_hdr(8'h40, 8'h01);
    bad  = 0;
    prev = 8'h00;
    bus.in_vld = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_byte = 8'(8'h11 * (i + 1));
      @(negedge clk);
      if (!bus.in_rdy) bad++;
      if (i > 0 && (!bus.out_vld || bus.out_byte != prev)) bad++;
      prev = bus.in_byte;
      @(posedge clk);
      #1;
    end
    bus.in_vld = 1'b0;
    @(negedge clk);
    if (!bus.out_vld || bus.out_byte != 8'h44) bad++;
    check("throughput.latency", 64'(bad), 64'd0);

    // Reset asserted mid-flush discards the held bytes.
    do_reset();
    send_hdr(8'h40, 8'h01);
    man_rdy = 1'b0;
    send_byte(8'h00);
    send_byte(8'h55);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("flush_reset.outputs", 64'({bus.in_rdy, bus.out_vld, bus.out_byte, bus.nal_type,
                                      bus.nal_tid, bus.nal_hdr_vld, bus.error_intr, bus.epb_cnt}),
          64'd0);
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    man_rdy = 1'b1;
    ob = got_out.size();
    hb = got_hdr.size();
    send_hdr(8'h40, 8'h01);
    send_byte(8'hAB);
    repeat (6) @(posedge clk);
    #1;
    v = 64'd0;
    for (int i = ob; i < got_out.size(); i++) v = {v[55:0], got_out[i]};
    lastv = (got_hdr.size() > hb) ? got_hdr[got_hdr.size()-1] : 9'h1FF;
    check("flush_reset.out_bytes", v, 64'hAB);
    check("flush_reset.out_len", 64'(got_out.size() - ob), 64'd1);
    check("flush_reset.hdr", 64'({got_hdr.size() - hb == 1, lastv}), 64'({1'b1, 6'd32, 3'd0}));

    // Randomized streams against the reference model.
    for (int it = 0; it < 6; it++) begin
      do_reset();
      stim.delete();
      stim.push_back(8'h00);
      stim.push_back(8'h00);
      stim.push_back(8'h01);
      stim.push_back(($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255))
                                                 : 8'($urandom_range(0, 127)));
      stim.push_back(8'($urandom_range(0, 255)));
      for (int i = 0; i < 70; i++) stim.push_back(rnd_byte());
      model_run();
      ob = got_out.size();
      hb = got_hdr.size();
      eb = got_err;
      rand_rdy = 1'b1;
      foreach (stim[i]) begin
        int gap;
        gap = $urandom_range(0, 2);
        if (gap > 0) begin
          repeat (gap) @(posedge clk);
          #1;
        end
        send_byte(stim[i]);
      end
      rand_rdy = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      bad = 0;
      for (int i = 0; i < exp_out.size(); i++) begin
        if (ob + i >= got_out.size() || got_out[ob+i] != exp_out[i]) bad++;
      end
      eb = got_err - eb;
      check($sformatf("rand%0d.out_len", it), 64'(got_out.size() - ob), 64'(exp_out.size()));
      check($sformatf("rand%0d.out_bytes", it), 64'(bad), 64'd0);
      bad = 0;
      for (int i = 0; i < exp_hdr.size(); i++) begin
        if (hb + i >= got_hdr.size() || got_hdr[hb+i] != exp_hdr[i]) bad++;
      end
      check($sformatf("rand%0d.hdr_cnt", it), 64'(got_hdr.size() - hb), 64'(exp_hdr.size()));
      check($sformatf("rand%0d.hdr_vals", it), 64'(bad), 64'd0);
      check($sformatf("rand%0d.err_cnt", it), 64'(eb), 64'(exp_err));
      check($sformatf("rand%0d.epb_cnt", it), 64'(bus.epb_cnt), 64'(exp_epb));
    end

    check("handshake_stability", 64'(stall_bad), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
